// File: rtl/inst_buffer_nw.sv
// inst_buffer_nw: multi-lane instruction FIFO between fetch and decode.
// Accepts up to IN_W fetched entries per cycle as an all-or-nothing group. Valid
// lanes are compacted in lane order. It presents the OUT_W oldest entries to decode,
// and decode pops a variable number of them each cycle.
// Ports:
//   clk, rst_n              clock (rising edge), async active-low reset
//   flush                   drop all contents; overrides same-cycle push/pop
//   pause                   freeze the pop side
//   push_valid/push_data    per-lane fetched entries, lane i at [i*DATA_W +: DATA_W]
//   push_ready              a full IN_W group fits this cycle
//   out_valid/out_data      oldest entries, lane 0 = oldest; invalid lanes read 0
//   pop_num                 entries consumed this cycle; clipped to occupancy
//   count                   current occupancy
// Optional feature macro INST_BUFFER_PERF_EN adds the saturating outputs
// perf_full_cyc and perf_empty_cyc.
module inst_buffer_nw #(
   parameter int unsigned IN_W   = 2,
   parameter int unsigned OUT_W  = 2,
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned DATA_W = 146
) (
   input  logic                         clk,
   input  logic                         rst_n,
`ifdef INST_BUFFER_PERF_EN
   output logic [31:0]                  perf_full_cyc,
   output logic [31:0]                  perf_empty_cyc,
`endif
   input  logic                         flush,
   input  logic                         pause,
   input  logic [IN_W-1:0]              push_valid,
   input  logic [IN_W*DATA_W-1:0]       push_data,
   output logic                         push_ready,
   output logic [OUT_W-1:0]             out_valid,
   output logic [OUT_W*DATA_W-1:0]      out_data,
   input  logic [$clog2(OUT_W+1)-1:0]   pop_num,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH+1);
   localparam int unsigned PN_W  = $clog2(IN_W+1);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [CNT_W-1:0]  cnt;

   logic              push_fire;
   logic [PN_W-1:0]   push_n;
   logic [CNT_W-1:0]  push_add;
   logic [CNT_W-1:0]  pop_eff;
   logic [IN_W-1:0]   wr_en;
   logic [PTR_W-1:0]  wr_idx [IN_W];
   logic [PTR_W-1:0]  rd_idx [OUT_W];

   // Ready depends only on the registered occupancy; same-cycle pops earn no credit.
   assign push_ready = (cnt <= CNT_W'(DEPTH - IN_W));
   assign push_fire  = push_ready && !flush;
   assign count      = cnt;

   // Lane compaction: each valid lane is written after all earlier valid lanes.
   always_comb begin
      push_n = '0;
      wr_en  = '0;
      for (int i = 0; i < int'(IN_W); i++) begin
         wr_idx[i] = wr_ptr + PTR_W'(push_n);
         wr_en[i]  = push_fire && push_valid[i];
         if (push_valid[i]) push_n = push_n + PN_W'(1);
      end
   end

   assign push_add = push_fire ? CNT_W'(push_n) : '0;

   // Pop is clipped to the occupancy and frozen while paused.
   always_comb begin
      pop_eff = '0;
      if (!pause) begin
         if (CNT_W'(pop_num) > cnt) pop_eff = cnt;
         else                       pop_eff = CNT_W'(pop_num);
      end
   end

   // Storage array; contents are not reset.
   always_ff @(posedge clk) begin
      for (int i = 0; i < int'(IN_W); i++) begin
         if (wr_en[i]) mem[wr_idx[i]] <= push_data[i*DATA_W +: DATA_W];
      end
   end

   // Pointers and occupancy; flush wins over push and pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         wr_ptr <= wr_ptr + PTR_W'(push_add);
         rd_ptr <= rd_ptr + PTR_W'(pop_eff);
         cnt    <= cnt + push_add - pop_eff;
      end
   end

   // Read lanes wrap modulo DEPTH through the pointer width.
   always_comb begin
      out_valid = '0;
      out_data  = '0;
      for (int i = 0; i < int'(OUT_W); i++) begin
         rd_idx[i]    = rd_ptr + PTR_W'(i);
         out_valid[i] = (cnt > CNT_W'(i));
         if (out_valid[i]) out_data[i*DATA_W +: DATA_W] = mem[rd_idx[i]];
      end
   end

`ifdef INST_BUFFER_PERF_EN
   // Saturating stall/starve counters; only reset clears them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_full_cyc  <= '0;
         perf_empty_cyc <= '0;
      end else begin
         if ((push_valid != '0) && !push_ready && (perf_full_cyc != '1))
            perf_full_cyc <= perf_full_cyc + 32'd1;
         if ((cnt == '0) && !pause && (perf_empty_cyc != '1))
            perf_empty_cyc <= perf_empty_cyc + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_inst_buffer_nw.sv
// tb_inst_buffer_nw: scoreboard bench for inst_buffer_nw (default parameters).
// Stimulus queues every accepted entry; a monitor pops and compares each entry
// the DUT presents on a lane being consumed. Directed checks cover the occupancy,
// the ready/valid flags and specific lane contents.
module tb_inst_buffer_nw;

   localparam int unsigned DATA_W = 146;
   localparam logic [31:0] BASE   = 32'h1c00_0000;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 flush, pause;
   logic [1:0]           push_valid;
   logic [2*DATA_W-1:0]  push_data;
   logic                 push_ready;
   logic [1:0]           out_valid;
   logic [2*DATA_W-1:0]  out_data;
   logic [1:0]           pop_num;
   logic [4:0]           count;

   logic [DATA_W-1:0]    exp_q [$];
   int                   total  = 0;
   int                   passed = 0;

   inst_buffer_nw dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .pause      (pause),
      .push_valid (push_valid),
      .push_data  (push_data),
      .push_ready (push_ready),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .pop_num    (pop_num),
      .count      (count)
   );

   always #5 clk = ~clk;

   function automatic logic [DATA_W-1:0] ent(input logic [31:0] pc);
      ent = {pc ^ 32'hdead_beef, 82'h0, pc};
   endfunction

   task automatic chk(input string name, input logic [DATA_W-1:0] act,
                      input logic [DATA_W-1:0] req);
      total++;
      if (act === req) passed++;
      else $display("FAIL %s: got %h required %h", name, act, req);
   endtask

   // Drive one cycle of inputs; acc marks a group the bench expects to be accepted.
   task automatic drive(input logic [1:0] pv, input logic [31:0] pc0, input logic [31:0] pc1,
                        input logic [1:0] pop, input logic fl, input logic pa, input logic acc);
      push_valid = pv;
      push_data  = {ent(pc1), ent(pc0)};
      pop_num    = pop;
      flush      = fl;
      pause      = pa;
      if (acc) begin
         if (pv[0]) exp_q.push_back(ent(pc0));
         if (pv[1]) exp_q.push_back(ent(pc1));
      end
      @(posedge clk);
      #1;
      push_valid = '0;
      push_data  = '0;
      pop_num    = '0;
      flush      = 1'b0;
      pause      = 1'b0;
   endtask

   task automatic chk_state(input string name, input int c, input logic rdy, input logic [1:0] v);
      chk({name, "_count"}, DATA_W'(count), DATA_W'(c));
      chk({name, "_ready"}, DATA_W'(push_ready), DATA_W'(rdy));
      chk({name, "_valid"}, DATA_W'(out_valid), DATA_W'(v));
   endtask

   function automatic logic [31:0] lane_pc(input int i);
      logic [DATA_W-1:0] d;
      d = out_data[i*DATA_W +: DATA_W];
      lane_pc = d[31:0];
   endfunction

   // Monitor: every valid lane consumed this cycle must match the queue head.
   initial begin
      logic [DATA_W-1:0] e;
      forever begin
         @(negedge clk);
         if (rst_n && !flush && !pause) begin
            for (int i = 0; i < 2; i++) begin
               if (int'(pop_num) > i && out_valid[i]) begin
                  if (exp_q.size() == 0) begin
                     total++;
                     $display("FAIL pop_lane%0d: got %h required no entry", i,
                              out_data[i*DATA_W +: DATA_W]);
                  end else begin
                     e = exp_q.pop_front();
                     chk($sformatf("pop_lane%0d", i), out_data[i*DATA_W +: DATA_W], e);
                  end
               end
            end
         end
      end
   end

   initial begin
      rst_n      = 1'b0;
      flush      = 1'b0;
      pause      = 1'b0;
      push_valid = '0;
      push_data  = '0;
      pop_num    = '0;
      #12;
      chk_state("reset", 0, 1'b1, 2'b00);
      chk("reset_data", out_data[DATA_W-1:0], '0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // First group visible one cycle later.
      drive(2'b11, BASE, BASE + 32'd4, 2'd0, 1'b0, 1'b0, 1'b1);
      chk_state("first", 2, 1'b1, 2'b11);
      chk("first_lane0", DATA_W'(lane_pc(0)), DATA_W'(32'h1c00_0000));
      chk("first_lane1", DATA_W'(lane_pc(1)), DATA_W'(32'h1c00_0004));

      // Fill to DEPTH, then an ignored 9th group.
      for (int g = 1; g < 8; g++)
         drive(2'b11, BASE + 32'(8*g), BASE + 32'(8*g + 4), 2'd0, 1'b0, 1'b0, 1'b1);
      chk_state("full", 16, 1'b0, 2'b11);
      drive(2'b11, 32'h2000_0000, 32'h2000_0004, 2'd0, 1'b0, 1'b0, 1'b0);
      chk_state("full_ignore", 16, 1'b0, 2'b11);

      // Drain to 3 entries (rd_ptr = 13).
      for (int k = 0; k < 6; k++) drive(2'b00, 0, 0, 2'd2, 1'b0, 1'b0, 1'b0);
      drive(2'b00, 0, 0, 2'd1, 1'b0, 1'b0, 1'b0);
      chk("hold3_count", DATA_W'(count), DATA_W'(3));

      // Pop 2 plus push 2: count holds, lane0 is the former 3rd entry at mem[15].
      drive(2'b11, BASE + 32'd64, BASE + 32'd68, 2'd2, 1'b0, 1'b0, 1'b1);
      chk_state("pushpop", 3, 1'b1, 2'b11);
      chk("wrap_lane0", DATA_W'(lane_pc(0)), DATA_W'(32'h1c00_003c));
      chk("wrap_lane1", DATA_W'(lane_pc(1)), DATA_W'(32'h1c00_0040));

      drive(2'b00, 0, 0, 2'd2, 1'b0, 1'b0, 1'b0);
      chk_state("wrap_pop", 1, 1'b1, 2'b01);
      chk("wrap_pop_lane0", DATA_W'(lane_pc(0)), DATA_W'(32'h1c00_0044));
      chk("invalid_lane_zero", out_data[DATA_W +: DATA_W], '0);

      // Over-request clipped to occupancy.
      drive(2'b00, 0, 0, 2'd2, 1'b0, 1'b0, 1'b0);
      chk_state("underflow", 0, 1'b1, 2'b00);

      // Pause freezes the pop side.
      drive(2'b11, 32'h1c00_1000, 32'h1c00_1004, 2'd0, 1'b0, 1'b0, 1'b1);
      drive(2'b11, 32'h1c00_1008, 32'h1c00_100c, 2'd0, 1'b0, 1'b0, 1'b1);
      chk("pre_pause_count", DATA_W'(count), DATA_W'(4));
      drive(2'b00, 0, 0, 2'd2, 1'b0, 1'b1, 1'b0);
      chk("pause_count", DATA_W'(count), DATA_W'(4));
      chk("pause_lane0", DATA_W'(lane_pc(0)), DATA_W'(32'h1c00_1000));

      // Flush beats same-cycle push and pop.
      drive(2'b01, 32'h1c00_1010, 0, 2'd0, 1'b0, 1'b0, 1'b1);
      chk("pre_flush_count", DATA_W'(count), DATA_W'(5));
      exp_q.delete();
      drive(2'b11, 32'h1c00_2000, 32'h1c00_2004, 2'd2, 1'b1, 1'b0, 1'b0);
      chk_state("flush", 0, 1'b1, 2'b00);

      // Stream to wr_ptr = 15, then a group straddling index 15 -> 0.
      for (int k = 0; k < 7; k++)
         drive(2'b11, 32'h1c00_3000 + 32'(8*k), 32'h1c00_3004 + 32'(8*k), 2'd2, 1'b0, 1'b0, 1'b1);
      chk("stream_count", DATA_W'(count), DATA_W'(2));
      drive(2'b10, 32'h0bad_0000, 32'h1c00_3038, 2'd0, 1'b0, 1'b0, 1'b1);
      drive(2'b11, 32'h1c00_303c, 32'h1c00_3040, 2'd0, 1'b0, 1'b0, 1'b1);
      chk("straddle_count", DATA_W'(count), DATA_W'(5));
      for (int k = 0; k < 3; k++) drive(2'b00, 0, 0, 2'd2, 1'b0, 1'b0, 1'b0);
      chk_state("drain", 0, 1'b1, 2'b00);
      chk("queue_empty", DATA_W'(exp_q.size()), '0);

      // Asynchronous reset mid-operation.
      drive(2'b11, 32'h1c00_4000, 32'h1c00_4004, 2'd0, 1'b0, 1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk_state("async_rst", 0, 1'b1, 2'b00);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
